fetch_thread_scheduler: RTL and testbench

- Per-cycle SMT fetch arbiter in front of the I-cache/decoder/aligner path.
- Holds one word-address PC and one state per hardware thread.
- Each cycle it picks one eligible thread round-robin and issues that thread's PC as the fetch request.
- One cycle after issue it consumes the aligner's valid mask, then advances the thread PC or parks the thread until the branch unit redirects it.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/fetch_thread_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_fetch_thread_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared definitions for the SMT fetch front end: per-thread state
//            encodings, fetch-group size and a 4-bit popcount helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    READY    = 2'b01,
    INFLIGHT = 2'b10,
    WAIT_BR  = 2'b11
  } thread_state_e;

  // Instructions per fetch group; also the minimum free queue space a thread
  // needs before it may be issued.
  localparam int FETCH_GROUP = 4;

  function automatic logic [2:0] popcount4(input logic [3:0] mask);
    popcount4 = 3'(mask[0]) + 3'(mask[1]) + 3'(mask[2]) + 3'(mask[3]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin arbiter. The search starts at the
//            requester after i_ptr (wrapping) and the first requester wins.
// Ports    : i_req       - request vector, one bit per requester
//            i_ptr       - id of the last granted requester
//            o_grant     - one-hot grant
//            o_grant_tid - binary id of the granted requester
//            o_grant_any - a grant was made
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int TID_WIDTH = 1
) (
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [TID_WIDTH-1:0] i_ptr,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic [TID_WIDTH-1:0] o_grant_tid,
  output logic                 o_grant_any
);

  // Requests rotated so that bit 0 is the requester right after i_ptr.
  // Doubling the vector makes the wrap-around fall out of a plain shift.
  logic [NUM_REQ-1:0] w_rot;
  int                 w_sum;

  always_comb begin
    w_rot       = NUM_REQ'({i_req, i_req} >> ({1'b0, i_ptr} + 1'b1));
    o_grant_any = 1'b0;
    w_sum       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!o_grant_any && w_rot[k]) begin
        o_grant_any = 1'b1;
        w_sum       = int'(i_ptr) + 1 + k;
        if (w_sum >= NUM_REQ) begin
          w_sum = w_sum - NUM_REQ;
        end
      end
    end
    o_grant_tid = TID_WIDTH'(w_sum);
    o_grant     = o_grant_any ? (NUM_REQ'(1) << w_sum) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_thread_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fetch_thread_scheduler
// Purpose  : Per-cycle SMT fetch arbiter. Keeps a PC and state per hardware
//            thread, issues one eligible thread per cycle round-robin, and
//            consumes the aligner's valid mask one cycle after issue.
// Ports    : i_Clk/i_Reset_n        - clock, asynchronous active-low reset
//            i_Stall                - suppress new issue this cycle
//            i_start/i_start_pc     - one-hot thread start and its PC
//            i_qspace               - per-thread instruction-queue free slots
//            i_resp/i_resp_valid/i_resp_branch - aligner result for the
//                                     previous cycle's issue
//            i_redirect/_tid/_pc    - branch-unit redirect
//            o_fetch_req/_tid/_pc   - registered fetch request
//            o_thread_state         - packed per-thread state (debug)
// Revision : 1.0 - initial release
// ============================================================================
module fetch_thread_scheduler
  import fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int NUM_THREADS   = 2,
  parameter int TID_WIDTH     = 1,
  parameter int QSPACE_WIDTH  = 4
) (
  input  logic                                i_Clk,
  input  logic                                i_Reset_n,
  input  logic                                i_Stall,
  input  logic [NUM_THREADS-1:0]              i_start,
  input  logic [ADDRESS_WIDTH-1:0]            i_start_pc,
  input  logic [NUM_THREADS*QSPACE_WIDTH-1:0] i_qspace,
  input  logic                                i_resp,
  input  logic [3:0]                          i_resp_valid,
  input  logic                                i_resp_branch,
  input  logic                                i_redirect,
  input  logic [TID_WIDTH-1:0]                i_redirect_tid,
  input  logic [ADDRESS_WIDTH-1:0]            i_redirect_pc,
  output logic                                o_fetch_req,
  output logic [TID_WIDTH-1:0]                o_fetch_tid,
  output logic [ADDRESS_WIDTH-1:0]            o_fetch_pc,
  output logic [2*NUM_THREADS-1:0]            o_thread_state
);

  thread_state_e            r_state     [NUM_THREADS];
  logic [ADDRESS_WIDTH-1:0] r_pc        [NUM_THREADS];
  thread_state_e            w_state_nxt [NUM_THREADS];
  logic [ADDRESS_WIDTH-1:0] w_pc_nxt    [NUM_THREADS];

  logic [NUM_THREADS-1:0]   r_squash;
  logic [NUM_THREADS-1:0]   w_squash_nxt;
  logic [NUM_THREADS-1:0]   w_slot;
  logic [NUM_THREADS-1:0]   w_redir;
  logic [NUM_THREADS-1:0]   w_take;
  logic [NUM_THREADS-1:0]   w_adv;
  logic [NUM_THREADS-1:0]   w_qspace_ok;
  logic [NUM_THREADS-1:0]   w_elig;
  logic [NUM_THREADS-1:0]   w_grant;
  logic [TID_WIDTH-1:0]     w_grant_tid;
  logic                     w_grant_any;
  logic [ADDRESS_WIDTH-1:0] w_grant_pc;

  logic [TID_WIDTH-1:0]     r_ptr;
  logic                     r_fetch_req;
  logic [TID_WIDTH-1:0]     r_fetch_tid;
  logic [ADDRESS_WIDTH-1:0] r_fetch_pc;
  // The fetch presented last cycle: i_resp this cycle belongs to it.
  logic                     r_pend_vld;
  logic [TID_WIDTH-1:0]     r_pend_tid;

  logic [2:0]               w_resp_cnt;

  assign w_resp_cnt = popcount4(i_resp_valid);

  // Per-thread next state / next PC and eligibility.
  always_comb begin
    w_slot       = '0;
    w_redir      = '0;
    w_take       = '0;
    w_adv        = '0;
    w_qspace_ok  = '0;
    w_elig       = '0;
    w_squash_nxt = r_squash;
    for (int t = 0; t < NUM_THREADS; t++) begin
      w_slot[t]  = r_pend_vld && (r_pend_tid == TID_WIDTH'(t));
      w_redir[t] = i_redirect && (i_redirect_tid == TID_WIDTH'(t));
      // A redirect in the same cycle beats the response.
      w_take[t]  = w_slot[t] && i_resp && (r_state[t] == INFLIGHT) &&
                   !r_squash[t] && !w_redir[t];
      w_adv[t]   = w_take[t] && !i_resp_branch;

      w_state_nxt[t] = r_state[t];
      w_pc_nxt[t]    = r_pc[t];
      // The response slot for this thread has passed; a squash is consumed.
      if (w_slot[t]) begin
        w_squash_nxt[t] = 1'b0;
      end

      case (r_state[t])
        IDLE: begin
          if (i_start[t]) begin
            w_state_nxt[t] = READY;
            w_pc_nxt[t]    = i_start_pc;
          end
        end
        READY: begin
          if (w_redir[t]) begin
            w_pc_nxt[t] = i_redirect_pc;
          end
        end
        INFLIGHT: begin
          if (w_redir[t]) begin
            w_state_nxt[t] = READY;
            w_pc_nxt[t]    = i_redirect_pc;
            // Its fetch is on the bus now, so the response arrives next
            // cycle and must be thrown away.
            if (r_fetch_req && (r_fetch_tid == TID_WIDTH'(t))) begin
              w_squash_nxt[t] = 1'b1;
            end
          end else if (w_take[t]) begin
            if (i_resp_branch) begin
              w_state_nxt[t] = WAIT_BR;
            end else begin
              w_state_nxt[t] = READY;
              w_pc_nxt[t]    = r_pc[t] + ADDRESS_WIDTH'(w_resp_cnt);
            end
          end
        end
        WAIT_BR: begin
          if (w_redir[t]) begin
            w_state_nxt[t] = READY;
            w_pc_nxt[t]    = i_redirect_pc;
          end
        end
        default: begin
          w_state_nxt[t] = IDLE;
        end
      endcase

      w_qspace_ok[t] = i_qspace[t*QSPACE_WIDTH +: QSPACE_WIDTH] >=
                       QSPACE_WIDTH'(FETCH_GROUP);
      // A thread whose response advances it this cycle may be re-issued at
      // once with the advanced PC; a thread that only just became READY by
      // start or redirect waits one cycle.
      w_elig[t] = w_qspace_ok[t] && !i_Stall &&
                  (((r_state[t] == READY) && !w_redir[t]) || w_adv[t]);
    end
  end

  rr_arbiter #(
    .NUM_REQ   (NUM_THREADS),
    .TID_WIDTH (TID_WIDTH)
  ) u_rr_arbiter (
    .i_req       (w_elig),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_grant_tid (w_grant_tid),
    .o_grant_any (w_grant_any)
  );

  always_comb begin
    w_grant_pc = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (w_grant[t]) begin
        w_grant_pc = w_pc_nxt[t];
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        r_state[t] <= IDLE;
        r_pc[t]    <= '0;
      end
      r_squash    <= '0;
      r_ptr       <= '0;
      r_fetch_req <= 1'b0;
      r_fetch_tid <= '0;
      r_fetch_pc  <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_tid  <= '0;
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        r_state[t] <= w_grant[t] ? INFLIGHT : w_state_nxt[t];
        r_pc[t]    <= w_pc_nxt[t];
      end
      r_squash    <= w_squash_nxt;
      r_fetch_req <= w_grant_any;
      // Tid/PC hold their last value when nothing is issued.
      if (w_grant_any) begin
        r_fetch_tid <= w_grant_tid;
        r_fetch_pc  <= w_grant_pc;
        r_ptr       <= w_grant_tid;
      end
      r_pend_vld <= r_fetch_req;
      r_pend_tid <= r_fetch_tid;
    end
  end

  always_comb begin
    o_thread_state = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      o_thread_state[2*t +: 2] = r_state[t];
    end
  end

  assign o_fetch_req = r_fetch_req;
  assign o_fetch_tid = r_fetch_tid;
  assign o_fetch_pc  = r_fetch_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_thread_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_thread_scheduler
// Purpose  : Self-checking bench for fetch_thread_scheduler. Directed stimulus
//            pushes the expected fetches (tid, pc, cycle) into a queue; a
//            monitor pops and compares on every o_fetch_req.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_thread_scheduler;

  logic        i_Clk = 1'b0;
  logic        i_Reset_n = 1'b0;
  logic        i_Stall = 1'b0;
  logic [1:0]  i_start = '0;
  logic [31:0] i_start_pc = '0;
  logic [7:0]  i_qspace = 8'h44;
  logic        i_resp = 1'b0;
  logic [3:0]  i_resp_valid = '0;
  logic        i_resp_branch = 1'b0;
  logic        i_redirect = 1'b0;
  logic [0:0]  i_redirect_tid = '0;
  logic [31:0] i_redirect_pc = '0;
  logic        o_fetch_req;
  logic [0:0]  o_fetch_tid;
  logic [31:0] o_fetch_pc;
  logic [3:0]  o_thread_state;

  fetch_thread_scheduler #(
    .ADDRESS_WIDTH (32),
    .NUM_THREADS   (2),
    .TID_WIDTH     (1),
    .QSPACE_WIDTH  (4)
  ) dut (
    .i_Clk          (i_Clk),
    .i_Reset_n      (i_Reset_n),
    .i_Stall        (i_Stall),
    .i_start        (i_start),
    .i_start_pc     (i_start_pc),
    .i_qspace       (i_qspace),
    .i_resp         (i_resp),
    .i_resp_valid   (i_resp_valid),
    .i_resp_branch  (i_resp_branch),
    .i_redirect     (i_redirect),
    .i_redirect_tid (i_redirect_tid),
    .i_redirect_pc  (i_redirect_pc),
    .o_fetch_req    (o_fetch_req),
    .o_fetch_tid    (o_fetch_tid),
    .o_fetch_pc     (o_fetch_pc),
    .o_thread_state (o_thread_state)
  );

  always #5 i_Clk = ~i_Clk;

  int cyc = 0;
  always @(posedge i_Clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          tid;
    logic [31:0] pc;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  // Monitor: every presented fetch must match the oldest expectation.
  always @(negedge i_Clk) begin
    exp_t e;
    while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_fetch expected tid=%0d pc=%0h at cycle %0d", e.tid, e.pc, e.cyc);
    end
    if (o_fetch_req) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_fetch actual tid=%0d pc=%0h cycle=%0d expected none",
                 o_fetch_tid, o_fetch_pc, cyc);
      end else begin
        e = exp_q.pop_front();
        if (int'(o_fetch_tid) != e.tid || o_fetch_pc != e.pc || cyc != e.cyc) begin
          errors++;
          $display("FAIL fetch actual tid=%0d pc=%0h cycle=%0d expected tid=%0d pc=%0h cycle=%0d",
                   o_fetch_tid, o_fetch_pc, cyc, e.tid, e.pc, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic goto(input int t);
    while (cyc < t) tick();
  endtask

  task automatic push(input int tid, input logic [31:0] pc, input int at);
    exp_t e;
    e.tid = tid;
    e.pc  = pc;
    e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drain(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s actual=%0d pending expected=0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic resp(input logic [3:0] mask, input logic br);
    i_resp        = 1'b1;
    i_resp_valid  = mask;
    i_resp_branch = br;
    tick();
    i_resp        = 1'b0;
    i_resp_valid  = '0;
    i_resp_branch = 1'b0;
  endtask

  task automatic do_reset(input string name);
    @(negedge i_Clk);
    #2;
    i_Reset_n = 1'b0;
    #1;
    chk({name, "_req"},   64'(o_fetch_req),    64'h0);
    chk({name, "_tid"},   64'(o_fetch_tid),    64'h0);
    chk({name, "_pc"},    64'(o_fetch_pc),     64'h0);
    chk({name, "_state"}, 64'(o_thread_state), 64'h0);
    i_Stall = 1'b0; i_start = '0; i_qspace = 8'h44; i_resp = 1'b0;
    i_resp_valid = '0; i_resp_branch = 1'b0; i_redirect = 1'b0;
    @(posedge i_Clk);
    @(posedge i_Clk);
    #1;
    i_Reset_n = 1'b1;
  endtask

  int b;

  initial begin
    // Initial reset
    tick();
    tick();
    chk("por_state", 64'(o_thread_state), 64'h0);
    chk("por_req",   64'(o_fetch_req),    64'h0);
    i_Reset_n = 1'b1;

    // Single thread: full mask advances by 4, empty mask by 0
    do_reset("rst1"); b = cyc;
    i_start = 2'b01; i_start_pc = 32'h10; push(0, 32'h10, b + 2);
    tick(); i_start = '0;
    goto(b + 3); push(0, 32'h14, b + 4); resp(4'b1111, 1'b0);
    goto(b + 5); push(0, 32'h14, b + 6); resp(4'b0000, 1'b0);
    goto(b + 9); drain("t1_drain");

    // Two threads interleave back-to-back
    do_reset("rst2"); b = cyc;
    i_start = 2'b01; i_start_pc = 32'h0;   push(0, 32'h0, b + 2);
    tick(); i_start = 2'b10; i_start_pc = 32'h100; push(1, 32'h100, b + 3);
    tick(); i_start = '0;
    goto(b + 3); push(0, 32'h4,   b + 4); resp(4'b1111, 1'b0);
    goto(b + 4); push(1, 32'h104, b + 5); resp(4'b1111, 1'b0);
    goto(b + 5); push(0, 32'h8,   b + 6); resp(4'b1111, 1'b0);
    goto(b + 10); drain("t2_drain");

    // Branch parks the thread; start on busy thread ignored; redirect resumes
    do_reset("rst3"); b = cyc;
    i_start = 2'b01; i_start_pc = 32'h2; push(0, 32'h2, b + 2);
    tick(); i_start = '0;
    goto(b + 3); resp(4'b1100, 1'b1);
    goto(b + 5); i_start = 2'b01; i_start_pc = 32'h999;
    tick(); i_start = '0;
    chk("t3_wait_br", 64'(o_thread_state), 64'h3);
    goto(b + 8); i_redirect = 1'b1; i_redirect_tid = 1'b0; i_redirect_pc = 32'h40;
    push(0, 32'h40, b + 10);
    tick(); i_redirect = 1'b0;
    goto(b + 13); drain("t3_drain");

    // Queue space below a fetch group blocks a thread
    do_reset("rst4"); b = cyc;
    i_qspace = 8'h34;
    i_start = 2'b11; i_start_pc = 32'h200; push(0, 32'h200, b + 2);
    tick(); i_start = '0;
    goto(b + 3); push(0, 32'h204, b + 4); resp(4'b1111, 1'b0);
    goto(b + 5); push(0, 32'h208, b + 6); resp(4'b1111, 1'b0);
    goto(b + 6); i_qspace = 8'h44; push(1, 32'h200, b + 7);
    goto(b + 7); push(0, 32'h20C, b + 8); resp(4'b1111, 1'b0);
    goto(b + 12); drain("t4_drain");

    // Redirect beats same-cycle response; squash discards the next response
    do_reset("rst5"); b = cyc;
    i_start = 2'b01; i_start_pc = 32'h60; push(0, 32'h60, b + 2);
    tick(); i_start = '0;
    goto(b + 3);
    i_redirect = 1'b1; i_redirect_tid = 1'b0; i_redirect_pc = 32'h80;
    push(0, 32'h80, b + 5);
    resp(4'b1111, 1'b0); i_redirect = 1'b0;
    goto(b + 5);
    i_redirect = 1'b1; i_redirect_pc = 32'hC0;
    tick(); i_redirect = 1'b0;
    push(0, 32'hC0, b + 7);
    resp(4'b1111, 1'b0);
    goto(b + 8); push(0, 32'hC4, b + 9); resp(4'b1111, 1'b0);
    goto(b + 12); drain("t5_drain");

    // PC wrap, stall with response, held tid/pc while idle
    do_reset("rst6"); b = cyc;
    i_start = 2'b10; i_start_pc = 32'hFFFF_FFFF; push(1, 32'hFFFF_FFFF, b + 2);
    tick(); i_start = '0;
    goto(b + 3); push(1, 32'h0, b + 4); resp(4'b1000, 1'b0);
    goto(b + 5); i_Stall = 1'b1; resp(4'b1111, 1'b0); i_Stall = 1'b0;
    chk("t6_req_stall", 64'(o_fetch_req), 64'h0);
    chk("t6_tid_hold",  64'(o_fetch_tid), 64'h1);
    chk("t6_pc_hold",   64'(o_fetch_pc),  64'h0);
    push(1, 32'h4, b + 7);
    goto(b + 7);
    chk("t6_inflight", 64'(o_thread_state), 64'h8);

    // Reset while t1 is in flight; the stale response afterwards is ignored
    do_reset("rst7");
    resp(4'b1111, 1'b0);
    chk("t7_state_after", 64'(o_thread_state), 64'h0);
    chk("t7_req_after",   64'(o_fetch_req),    64'h0);
    tick(); tick(); tick();
    chk("t7_state_late", 64'(o_thread_state), 64'h0);
    drain("t7_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
